// File: rtl/sobel_edge_detect_pkg.sv
// rtl/sobel_edge_detect_pkg.sv - shared widths, latency and helpers for the Sobel edge stage
package sobel_edge_detect_pkg;

  localparam int SOBEL_LAT = 3;
  localparam int PSUM_W    = 10;
  localparam int GRAD_W    = 11;
  localparam int MAG_W     = 11;

  localparam logic [7:0] EDGE_ON  = 8'd255;
  localparam logic [7:0] EDGE_OFF = 8'd0;

  // One side of a Sobel kernel: outer taps weight 1, centre tap weight 2.
  function automatic logic [PSUM_W-1:0] weighted_sum(input logic [7:0] a,
                                                     input logic [7:0] b,
                                                     input logic [7:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  function automatic logic [7:0] sat8(input logic [MAG_W-1:0] m);
    return (m > MAG_W'(255)) ? 8'hFF : m[7:0];
  endfunction

endpackage

// File: rtl/sobel_edge_detect_abs.sv
// rtl/sobel_edge_detect_abs.sv - registered absolute difference of two kernel partial sums
module sobel_abs_diff
  import sobel_edge_detect_pkg::*;
(
  input  logic              video_clk,
  input  logic              rst,
  input  logic [PSUM_W-1:0] a,
  input  logic [PSUM_W-1:0] b,
  output logic [PSUM_W-1:0] abs_diff
);

  logic signed [GRAD_W-1:0] diff;

  assign diff = signed'({1'b0, a}) - signed'({1'b0, b});

  // |diff| never exceeds 1020, so negating the low bits alone is exact.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      abs_diff <= '0;
    end else if (diff[GRAD_W-1]) begin
      abs_diff <= ~diff[PSUM_W-1:0] + PSUM_W'(1);
    end else begin
      abs_diff <= diff[PSUM_W-1:0];
    end
  end

endmodule

// File: rtl/sobel_edge_detect.sv
// rtl/sobel_edge_detect.sv - 3-stage Sobel magnitude, thresholding and border blanking
module sobel_edge_detect
  import sobel_edge_detect_pkg::*;
#(
  parameter int         IMG_WIDTH  = 1920,
  parameter int         IMG_HEIGHT = 1080,
  parameter logic [7:0] DEF_THRESH = 8'd64
) (
  input  logic       video_clk,
  input  logic       rst,
  input  logic       matrix_de,
  input  logic       matrix_vs,
  input  logic [7:0] matrix11,
  input  logic [7:0] matrix12,
  input  logic [7:0] matrix13,
  input  logic [7:0] matrix21,
  input  logic [7:0] matrix22,
  input  logic [7:0] matrix23,
  input  logic [7:0] matrix31,
  input  logic [7:0] matrix32,
  input  logic [7:0] matrix33,
  input  logic [7:0] thresh,
  output logic       edge_de,
  output logic       edge_vs,
  output logic [7:0] edge_data,
  output logic [7:0] edge_mag
);

  localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(IMG_HEIGHT - 1);

  logic [SOBEL_LAT-1:0] de_pipe;
  logic [SOBEL_LAT-1:0] vs_pipe;
  logic [PSUM_W-1:0]    gx_pos, gx_neg, gy_pos, gy_neg;
  logic [PSUM_W-1:0]    abs_gx, abs_gy;
  logic [MAG_W-1:0]     mag;
  logic [7:0]           thresh_r;
  logic [10:0]          x_cnt, y_cnt, x_cur, y_cur;
  logic                 locked, vs_rise, s2_valid, border;

  assign s2_valid = de_pipe[SOBEL_LAT-2];
  assign vs_rise  = vs_pipe[SOBEL_LAT-2] & ~vs_pipe[SOBEL_LAT-1];
  assign edge_de  = de_pipe[SOBEL_LAT-1];
  assign edge_vs  = vs_pipe[SOBEL_LAT-1];

  // S1: kernel partial sums; bubbles carry zeros.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      de_pipe <= '0;
      vs_pipe <= '0;
      gx_pos  <= '0;
      gx_neg  <= '0;
      gy_pos  <= '0;
      gy_neg  <= '0;
    end else begin
      de_pipe <= {de_pipe[SOBEL_LAT-2:0], matrix_de};
      vs_pipe <= {vs_pipe[SOBEL_LAT-2:0], matrix_vs};
      if (matrix_de) begin
        gx_pos <= weighted_sum(matrix13, matrix23, matrix33);
        gx_neg <= weighted_sum(matrix11, matrix21, matrix31);
        gy_pos <= weighted_sum(matrix31, matrix32, matrix33);
        gy_neg <= weighted_sum(matrix11, matrix12, matrix13);
      end else begin
        gx_pos <= '0;
        gx_neg <= '0;
        gy_pos <= '0;
        gy_neg <= '0;
      end
    end
  end

  // S2: gradient magnitudes.
  sobel_abs_diff u_abs_gx (
    .video_clk (video_clk),
    .rst       (rst),
    .a         (gx_pos),
    .b         (gx_neg),
    .abs_diff  (abs_gx)
  );

  sobel_abs_diff u_abs_gy (
    .video_clk (video_clk),
    .rst       (rst),
    .a         (gy_pos),
    .b         (gy_neg),
    .abs_diff  (abs_gy)
  );

  assign mag = MAG_W'(abs_gx) + MAG_W'(abs_gy);

  // Threshold is frame-stable: only a rising matrix_vs reloads it.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      thresh_r <= DEF_THRESH;
    end else if (matrix_vs && !vs_pipe[0]) begin
      thresh_r <= thresh;
    end
  end

  // Coordinate of the pixel entering S3; a coincident vs edge makes it (0,0).
  always_comb begin
    x_cur  = vs_rise ? '0 : x_cnt;
    y_cur  = vs_rise ? '0 : y_cnt;
    border = locked && ((x_cur == '0) || (x_cur == X_LAST) ||
                        (y_cur == '0) || (y_cur == Y_LAST));
  end

  // Until the first vs edge after reset the position is unknown, so no blanking.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      locked <= 1'b0;
    end else begin
      if (vs_rise) begin
        locked <= 1'b1;
      end
      if (s2_valid) begin
        if (x_cur == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cur == Y_LAST) ? '0 : y_cur + 11'd1;
        end else begin
          x_cnt <= x_cur + 11'd1;
          y_cnt <= y_cur;
        end
      end else if (vs_rise) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
    end
  end

  // S3: saturated magnitude and binary edge, zeroed on bubbles and borders.
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      edge_data <= EDGE_OFF;
      edge_mag  <= EDGE_OFF;
    end else if (s2_valid && !border) begin
      edge_mag  <= sat8(mag);
      edge_data <= (mag >= MAG_W'(thresh_r)) ? EDGE_ON : EDGE_OFF;
    end else begin
      edge_data <= EDGE_OFF;
      edge_mag  <= EDGE_OFF;
    end
  end

endmodule
